// File: rtl/lsu_mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_stage_pkg
// Brief    : Shared encodings, op record and alignment helpers for the LSU.
// Revision : 1.0
// ============================================================================
package lsu_mem_stage_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] LSU_SIZE_B = 2'b00;
    localparam logic [1:0] LSU_SIZE_H = 2'b01;
    localparam logic [1:0] LSU_SIZE_W = 2'b10;

    localparam logic [1:0] LSU_ST_IDLE = 2'd0;
    localparam logic [1:0] LSU_ST_REQ  = 2'd1;
    localparam logic [1:0] LSU_ST_RSP  = 2'd2;
    localparam logic [1:0] LSU_ST_DONE = 2'd3;

    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       is_unsigned;
    } lsu_op_t;

    // Size code 2'b11 behaves exactly like a word access.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            LSU_SIZE_B: return 1'b0;
            LSU_SIZE_H: return off[0];
            default:    return |off;
        endcase
    endfunction

    function automatic logic [1:0] lsu_align_offset(input logic [1:0] size, input logic [1:0] off);
        case (size)
            LSU_SIZE_B: return off;
            LSU_SIZE_H: return {off[1], 1'b0};
            default:    return 2'b00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_stage_if
// Brief    : EX request, memory bus and writeback signals of the LSU.
// Revision : 1.0
// ============================================================================
interface lsu_mem_stage_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int RD_WIDTH   = 5
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic [RD_WIDTH-1:0]   req_rd;

    logic                  bus_req_valid;
    logic                  bus_req_ready;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic                  bus_we;
    logic [3:0]            bus_wstrb;
    logic [31:0]           bus_wdata;
    logic                  bus_rsp_valid;
    logic [31:0]           bus_rdata;

    logic                  wb_valid;
    logic [RD_WIDTH-1:0]   wb_rd;
    logic [31:0]           wb_data;
    logic                  wb_excp;

    // Environment side: EX stage, memory model and writeback consumer.
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
        output bus_req_ready, bus_rsp_valid, bus_rdata,
        input  req_ready, bus_req_valid, bus_addr, bus_we, bus_wstrb, bus_wdata,
        input  wb_valid, wb_rd, wb_data, wb_excp
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
        input  bus_req_ready, bus_rsp_valid, bus_rdata,
        output req_ready, bus_req_valid, bus_addr, bus_we, bus_wstrb, bus_wdata,
        output wb_valid, wb_rd, wb_data, wb_excp
    );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_stage_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_stage_align
// Brief    : Store lane steering/strobes and load extract/extend (combinational).
// Revision : 1.0
// ============================================================================
module lsu_mem_stage_align
    import lsu_mem_stage_pkg::*;
(
    input  wire logic [1:0]  i_size,
    input  wire logic [1:0]  i_offset,
    input  wire logic        i_unsigned,
    input  wire logic [31:0] i_st_data,
    input  wire logic [31:0] i_ld_word,
    output logic      [3:0]  o_wstrb,
    output logic      [31:0] o_wdata,
    output logic      [31:0] o_ld_data
);
    logic [31:0] w_shifted;

    always_comb begin
        w_shifted = i_ld_word >> {i_offset, 3'b000};
        o_wstrb   = 4'b1111;
        o_wdata   = i_st_data;
        o_ld_data = w_shifted;
        case (i_size)
            LSU_SIZE_B: begin
                o_wstrb   = 4'b0001 << i_offset;
                o_wdata   = {4{i_st_data[7:0]}};
                o_ld_data = i_unsigned ? {24'd0, w_shifted[7:0]}
                                       : {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            LSU_SIZE_H: begin
                o_wstrb   = 4'b0011 << {i_offset[1], 1'b0};
                o_wdata   = {2{i_st_data[15:0]}};
                o_ld_data = i_unsigned ? {16'd0, w_shifted[15:0]}
                                       : {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            default: begin
                o_wstrb   = 4'b1111;
                o_wdata   = i_st_data;
                o_ld_data = w_shifted;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_stage
// Brief    : Single-outstanding load/store unit between EX and writeback.
//            Build option LSU_MISALIGN_EXC_EN: trap misaligned ops instead of
//            silently aligning them.
// Revision : 1.0
// ============================================================================
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = DATA_WIDTH,
    parameter int RD_WIDTH   = 5
) (
    input  wire            clk,
    input  wire            rst,
    lsu_mem_stage_if.slave bus
);
    logic [1:0]            r_state;
    lsu_op_t               r_op;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [RD_WIDTH-1:0]   r_rd;
    logic [RD_WIDTH-1:0]   r_wb_rd;
    logic [DATA_WIDTH-1:0] r_wb_data;

    logic                  w_misal;
    logic                  w_to_done;
    logic [ADDR_WIDTH-1:0] w_cap_addr;
    logic [3:0]            w_wstrb;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_ld_data;

`ifdef LSU_MISALIGN_EXC_EN
    assign w_misal    = lsu_misaligned(bus.req_size, bus.req_addr[1:0]);
    assign w_cap_addr = bus.req_addr;
`else
    // Without the trap the low address bits are simply forced to alignment.
    assign w_misal    = 1'b0;
    assign w_cap_addr = {bus.req_addr[ADDR_WIDTH-1:2],
                         lsu_align_offset(bus.req_size, bus.req_addr[1:0])};
`endif

    assign w_to_done = ((r_state == LSU_ST_IDLE) && bus.req_valid && w_misal) ||
                       ((r_state == LSU_ST_REQ)  && bus.bus_req_ready && r_op.we) ||
                       ((r_state == LSU_ST_RSP)  && bus.bus_rsp_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= LSU_ST_IDLE;
            r_op      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rd      <= '0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
        end else begin
            case (r_state)
                LSU_ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_op.we          <= bus.req_we;
                        r_op.size        <= bus.req_size;
                        r_op.is_unsigned <= bus.req_unsigned;
                        r_addr           <= w_cap_addr;
                        r_wdata          <= bus.req_wdata;
                        r_rd             <= bus.req_rd;
                        r_state          <= w_misal ? LSU_ST_DONE : LSU_ST_REQ;
                    end
                end
                LSU_ST_REQ: begin
                    if (bus.bus_req_ready) begin
                        r_state <= r_op.we ? LSU_ST_DONE : LSU_ST_RSP;
                    end
                end
                LSU_ST_RSP: begin
                    if (bus.bus_rsp_valid) begin
                        r_state <= LSU_ST_DONE;
                    end
                end
                LSU_ST_DONE: r_state <= LSU_ST_IDLE;
                default:     r_state <= LSU_ST_IDLE;
            endcase

            // Writeback fields change only on entry to DONE and hold afterwards.
            if (w_to_done) begin
                r_wb_rd <= (r_state == LSU_ST_RSP) ? r_rd : '0;
                if (r_state == LSU_ST_RSP) begin
                    r_wb_data <= w_ld_data;
                end else if (r_state == LSU_ST_IDLE) begin
                    r_wb_data <= DATA_WIDTH'(bus.req_addr);
                end else begin
                    r_wb_data <= '0;
                end
            end
        end
    end

`ifdef LSU_MISALIGN_EXC_EN
    logic r_wb_excp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_excp <= 1'b0;
        end else if (w_to_done) begin
            r_wb_excp <= (r_state == LSU_ST_IDLE);
        end
    end

    assign bus.wb_excp = r_wb_excp;
`else
    assign bus.wb_excp = 1'b0;
`endif

    lsu_mem_stage_align u_align (
        .i_size     (r_op.size),
        .i_offset   (r_addr[1:0]),
        .i_unsigned (r_op.is_unsigned),
        .i_st_data  (r_wdata),
        .i_ld_word  (bus.bus_rdata),
        .o_wstrb    (w_wstrb),
        .o_wdata    (w_wdata),
        .o_ld_data  (w_ld_data)
    );

    assign bus.req_ready     = (r_state == LSU_ST_IDLE);
    assign bus.bus_req_valid = (r_state == LSU_ST_REQ);
    assign bus.bus_addr      = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign bus.bus_we        = r_op.we;
    assign bus.bus_wstrb     = r_op.we ? w_wstrb : 4'b0000;
    assign bus.bus_wdata     = r_op.we ? w_wdata : '0;
    assign bus.wb_valid      = (r_state == LSU_ST_DONE);
    assign bus.wb_rd         = r_wb_rd;
    assign bus.wb_data       = r_wb_data;
endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_stage
// Brief    : Directed self-checking bench with a byte-level reference model.
// Revision : 1.0
// ============================================================================
module tb_lsu_mem_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

`ifdef LSU_MISALIGN_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    lsu_mem_stage_if #(.ADDR_WIDTH(32), .RD_WIDTH(5)) ifc ();

    lsu_mem_stage #(.ADDR_WIDTH(32), .RD_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        excp;
    } wb_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        e_we, e_uns;
    logic [1:0]  e_size;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [4:0]  e_rd;
    bit          op_active = 1'b0;
    int          wb_pulses = 0;
    int          wb_cyc    = 0;
    int          last_lat  = 0;
    wb_t         last_wb   = '0;
    logic [31:0] obs_bus_addr = '0, obs_wdata = '0, obs_wb_data = '0;
    logic [3:0]  obs_wstrb = '0;
    logic [4:0]  obs_wb_rd = '0;
    logic        obs_wb_excp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model: byte-lane view of the access ----------------
    function automatic int m_bytes(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit m_misal(input logic [1:0] s, input logic [31:0] a);
        return (a % m_bytes(s)) != 0;
    endfunction

    function automatic int m_off(input logic [1:0] s, input logic [31:0] a);
        int o;
        o = a % 4;
        return o - (o % m_bytes(s));
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [1:0] s, input logic [31:0] a);
        logic [3:0] r;
        int o, n;
        o = m_off(s, a);
        n = m_bytes(s);
        for (int i = 0; i < 4; i++) r[i] = (i >= o) && (i < o + n);
        return r;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] s, input logic [31:0] d);
        logic [31:0] r;
        int n;
        n = m_bytes(s);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] s, input logic u,
                                           input logic [31:0] a, input logic [31:0] rdata);
        logic [31:0] r;
        int o, n;
        o = m_off(s, a);
        n = m_bytes(s);
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = rdata[8*(o+i) +: 8];
        if (!u && n < 4 && r[8*n-1]) begin
            for (int i = n; i < 4; i++) r[8*i +: 8] = 8'hFF;
        end
        return r;
    endfunction

    function automatic bit skip_now();
        return EXC_EN && m_misal(e_size, e_addr);
    endfunction

    function automatic wb_t m_wb();
        wb_t w;
        w = '0;
        if (skip_now()) begin
            w.data = e_addr;
            w.excp = 1'b1;
        end else if (!e_we) begin
            w.rd   = e_rd;
            w.data = m_load(e_size, e_uns, e_addr, e_rdata);
        end
        return w;
    endfunction

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("req_ready", {31'd0, ifc.req_ready}, {31'd0, !op_active});
            if (ifc.bus_req_valid) begin
                if (!op_active || skip_now()) begin
                    checks++;
                    failures++;
                    $display("FAIL bus_req_valid: got 1 expected 0 at cycle %0d", cyc);
                end else begin
                    check("bus_addr", ifc.bus_addr, e_addr - (e_addr % 4));
                    check("bus_we", {31'd0, ifc.bus_we}, {31'd0, e_we});
                    check("bus_wstrb", {28'd0, ifc.bus_wstrb},
                          {28'd0, (e_we ? m_wstrb(e_size, e_addr) : 4'b0000)});
                    if (e_we) check("bus_wdata", ifc.bus_wdata, m_wdata(e_size, e_wdata));
                    obs_bus_addr = ifc.bus_addr;
                    obs_wstrb    = ifc.bus_wstrb;
                    obs_wdata    = ifc.bus_wdata;
                end
            end
            if (ifc.wb_valid) begin
                wb_t w;
                wb_pulses++;
                wb_cyc = cyc;
                if (!op_active) begin
                    checks++;
                    failures++;
                    $display("FAIL wb_valid: got 1 expected 0 at cycle %0d", cyc);
                end else begin
                    w = m_wb();
                    check("wb_rd", {27'd0, ifc.wb_rd}, {27'd0, w.rd});
                    check("wb_data", ifc.wb_data, w.data);
                    check("wb_excp", {31'd0, ifc.wb_excp}, {31'd0, w.excp});
                    last_wb   = w;
                    op_active = 1'b0;
                end
                obs_wb_rd   = ifc.wb_rd;
                obs_wb_data = ifc.wb_data;
                obs_wb_excp = ifc.wb_excp;
            end else begin
                check("wb_rd_hold", {27'd0, ifc.wb_rd}, {27'd0, last_wb.rd});
                check("wb_data_hold", ifc.wb_data, last_wb.data);
                check("wb_excp_hold", {31'd0, ifc.wb_excp}, {31'd0, last_wb.excp});
            end
        end
    end

    // ---------------- one full operation with a scripted memory ----------------
    task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                          input logic [31:0] rdata, input int rdly, input int sdly);
        int start, n, p0, lat;
        bit skip;
        @(posedge clk); #1;
        e_we = we; e_size = size; e_uns = uns; e_addr = addr;
        e_wdata = wdata; e_rd = rd; e_rdata = rdata;
        skip = skip_now();
        ifc.req_valid = 1'b1; ifc.req_we = we; ifc.req_size = size; ifc.req_unsigned = uns;
        ifc.req_addr = addr; ifc.req_wdata = wdata; ifc.req_rd = rd;
        @(posedge clk); #1;
        op_active = 1'b1;
        start     = cyc;
        p0        = wb_pulses;
        // Scramble request inputs so only captured values can reach the bus.
        ifc.req_valid = 1'b0; ifc.req_we = ~we; ifc.req_size = ~size; ifc.req_unsigned = ~uns;
        ifc.req_addr = ~addr; ifc.req_wdata = ~wdata; ifc.req_rd = ~rd;
        if (!skip) begin
            for (int i = 0; i < rdly; i++) begin
                check("stall_req_valid", {31'd0, ifc.bus_req_valid}, 32'd1);
                ifc.bus_rsp_valid = 1'b1;
                ifc.bus_rdata     = 32'hBADC0FFE;
                @(posedge clk); #1;
            end
            ifc.bus_rsp_valid = 1'b0;
            ifc.bus_req_ready = 1'b1;
            @(posedge clk); #1;
            ifc.bus_req_ready = 1'b0;
            if (!we) begin
                repeat (sdly) begin @(posedge clk); #1; end
                ifc.bus_rsp_valid = 1'b1;
                ifc.bus_rdata     = rdata;
                @(posedge clk); #1;
                ifc.bus_rsp_valid = 1'b0;
                ifc.bus_rdata     = 32'h0;
            end
        end
        n = 0;
        while (wb_pulses == p0 && n < 10) begin @(posedge clk); #1; n++; end
        lat = skip ? 0 : (we ? 1 + rdly : 2 + rdly + sdly);
        last_lat = wb_cyc - start;
        check("wb_latency", last_lat, lat);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("wb_pulse_count", wb_pulses - p0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        rst = 1'b1;
        ifc.req_valid = 1'b0; ifc.req_we = 1'b0; ifc.req_size = 2'b00; ifc.req_unsigned = 1'b0;
        ifc.req_addr = '0; ifc.req_wdata = '0; ifc.req_rd = '0;
        ifc.bus_req_ready = 1'b0; ifc.bus_rsp_valid = 1'b0; ifc.bus_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_req_ready", {31'd0, ifc.req_ready}, 32'd1);
        check("rst_bus_req_valid", {31'd0, ifc.bus_req_valid}, 32'd0);
        check("rst_bus_we", {31'd0, ifc.bus_we}, 32'd0);
        check("rst_bus_wstrb", {28'd0, ifc.bus_wstrb}, 32'd0);
        check("rst_bus_addr", ifc.bus_addr, 32'd0);
        check("rst_bus_wdata", ifc.bus_wdata, 32'd0);
        check("rst_wb_valid", {31'd0, ifc.wb_valid}, 32'd0);
        check("rst_wb_data", ifc.wb_data, 32'd0);
        check("rst_wb_rd", {27'd0, ifc.wb_rd}, 32'd0);
        check("rst_wb_excp", {31'd0, ifc.wb_excp}, 32'd0);

        // SW, memory ready immediately
        run_op(1'b1, 2'b10, 1'b0, 32'h0000_1000, 32'h1122_3344, 5'd7, 32'h0, 0, 0);
        check("sw_wstrb", {28'd0, obs_wstrb}, 32'h0000_000F);
        check("sw_wdata", obs_wdata, 32'h1122_3344);
        check("sw_wb_rd", {27'd0, obs_wb_rd}, 32'd0);
        check("sw_latency", last_lat, 1);

        // SB to the top byte lane
        run_op(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB, 5'd2, 32'h0, 0, 0);
        check("sb_wstrb", {28'd0, obs_wstrb}, 32'h0000_0008);
        check("sb_wdata", obs_wdata, 32'hABAB_ABAB);
        check("sb_bus_addr", obs_bus_addr, 32'h0000_1000);

        // Sign/zero extension
        run_op(1'b0, 2'b00, 1'b0, 32'h0000_1001, 32'h0, 5'd3, 32'h0080_FF00, 0, 0);
        check("lb_wb_data", obs_wb_data, 32'hFFFF_FFFF);
        check("lb_wb_rd", {27'd0, obs_wb_rd}, 32'd3);
        run_op(1'b0, 2'b00, 1'b1, 32'h0000_1001, 32'h0, 5'd4, 32'h0080_FF00, 0, 0);
        check("lbu_wb_data", obs_wb_data, 32'h0000_00FF);
        run_op(1'b0, 2'b01, 1'b0, 32'h0000_1002, 32'h0, 5'd5, 32'h0080_FF00, 0, 0);
        check("lh_wb_data", obs_wb_data, 32'h0000_0080);
        run_op(1'b0, 2'b01, 1'b1, 32'h0000_1000, 32'h0, 5'd6, 32'h1234_FFFE, 0, 0);
        check("lhu_wb_data", obs_wb_data, 32'h0000_FFFE);

        // Back-pressure: 3 stall cycles with stray responses, then 2-cycle-late data
        run_op(1'b0, 2'b10, 1'b0, 32'h0000_2008, 32'h0, 5'd9, 32'hDEAD_BEEF, 3, 2);
        check("stall_wb_data", obs_wb_data, 32'hDEAD_BEEF);
        check("stall_latency", last_lat, 7);

        // SH to upper half, size 2'b11 store behaves as word
        run_op(1'b1, 2'b01, 1'b0, 32'h0000_1006, 32'h1234_ABCD, 5'd1, 32'h0, 0, 0);
        check("sh_wstrb", {28'd0, obs_wstrb}, 32'h0000_000C);
        check("sh_wdata", obs_wdata, 32'hABCD_ABCD);
        run_op(1'b1, 2'b11, 1'b0, 32'h0000_3000, 32'hCAFE_0001, 5'd1, 32'h0, 1, 0);
        check("s11_wstrb", {28'd0, obs_wstrb}, 32'h0000_000F);

        // Misaligned word load
        run_op(1'b0, 2'b10, 1'b0, 32'h0000_1002, 32'h0, 5'd8, 32'hCAFE_F00D, 0, 0);
`ifdef LSU_MISALIGN_EXC_EN
        check("lw_mis_excp", {31'd0, obs_wb_excp}, 32'd1);
        check("lw_mis_data", obs_wb_data, 32'h0000_1002);
        check("lw_mis_rd", {27'd0, obs_wb_rd}, 32'd0);
`else
        check("lw_mis_bus_addr", obs_bus_addr, 32'h0000_1000);
        check("lw_mis_data", obs_wb_data, 32'hCAFE_F00D);
        check("lw_mis_excp", {31'd0, obs_wb_excp}, 32'd0);
`endif
        // Misaligned half load and store, model-checked in either build
        run_op(1'b0, 2'b01, 1'b0, 32'h0000_1003, 32'h0, 5'd10, 32'h8001_0000, 0, 0);
        run_op(1'b1, 2'b01, 1'b0, 32'h0000_1001, 32'h0000_5A5A, 5'd11, 32'h0, 0, 0);

        // Reset while waiting for load data; a late response must be ignored
        @(posedge clk); #1;
        e_we = 1'b0; e_size = 2'b10; e_uns = 1'b0; e_addr = 32'h0000_4000;
        e_wdata = 32'h0; e_rd = 5'd12; e_rdata = 32'h1357_9BDF;
        ifc.req_valid = 1'b1; ifc.req_we = 1'b0; ifc.req_size = 2'b10; ifc.req_unsigned = 1'b0;
        ifc.req_addr = 32'h0000_4000; ifc.req_rd = 5'd12;
        @(posedge clk); #1;
        op_active = 1'b1;
        ifc.req_valid = 1'b0;
        ifc.bus_req_ready = 1'b1;
        @(posedge clk); #1;
        ifc.bus_req_ready = 1'b0;
        p0 = wb_pulses;
        #2 rst = 1'b1;
        op_active = 1'b0;
        last_wb   = '0;
        #1;
        check("midrst_req_ready", {31'd0, ifc.req_ready}, 32'd1);
        check("midrst_wb_valid", {31'd0, ifc.wb_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ifc.bus_rsp_valid = 1'b1;
        ifc.bus_rdata     = 32'h1357_9BDF;
        @(posedge clk); #1;
        ifc.bus_rsp_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("midrst_no_wb", wb_pulses - p0, 0);
        check("midrst_req_ready_after", {31'd0, ifc.req_ready}, 32'd1);

        run_op(1'b0, 2'b00, 1'b1, 32'h0000_5002, 32'h0, 5'd13, 32'h00C3_0000, 0, 1);
        check("post_rst_lbu", obs_wb_data, 32'h0000_00C3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
